// File: rtl/ext_pipe.sv
// Registered immediate/load-data extender behind a 2-entry valid/ready skid buffer.
// Entry 0 is always the head, so every output comes straight from a register.
module ext_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [OFF_W-1:0]  in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_exc
);

    localparam logic [2:0] OP_WORD = 3'd0;
    localparam logic [2:0] OP_LBU  = 3'd1;
    localparam logic [2:0] OP_LB   = 3'd2;
    localparam logic [2:0] OP_LHU  = 3'd3;
    localparam logic [2:0] OP_LH   = 3'd4;
    localparam logic [2:0] OP_IMMZ = 3'd5;
    localparam logic [2:0] OP_IMMS = 3'd6;
    localparam logic [2:0] OP_LUI  = 3'd7;

    localparam logic [1:0] CNT_0 = 2'd0;
    localparam logic [1:0] CNT_1 = 2'd1;
    localparam logic [1:0] CNT_2 = 2'd2;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_res;
    logic              w_exc;

    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_res0, r_res1;
    logic              r_exc0, r_exc1;
    logic              r_in_ready, r_out_valid;

    logic [1:0]        w_count_nxt;
    logic [DATA_W-1:0] w_res0_nxt, w_res1_nxt;
    logic              w_exc0_nxt, w_exc1_nxt;
    logic              w_push, w_pop;

    assign w_byte = 8'(in_data >> {in_addr, 3'b000});
    assign w_half = 16'(in_data >> {in_addr, 3'b000});

    // Extension and misalignment detection on the incoming beat
    always_comb begin
        w_res = '0;
        w_exc = 1'b0;
        case (in_op)
            OP_WORD: begin
                if (in_addr != '0) w_exc = 1'b1;
                else               w_res = in_data;
            end
            OP_LBU:  w_res = {{(DATA_W-8){1'b0}}, w_byte};
            OP_LB:   w_res = {{(DATA_W-8){w_byte[7]}}, w_byte};
            OP_LHU: begin
                if (in_addr[0]) w_exc = 1'b1;
                else            w_res = {{(DATA_W-16){1'b0}}, w_half};
            end
            OP_LH: begin
                if (in_addr[0]) w_exc = 1'b1;
                else            w_res = {{(DATA_W-16){w_half[15]}}, w_half};
            end
            OP_IMMZ: w_res = {{(DATA_W-IMM_W){1'b0}}, in_imm};
            OP_IMMS: w_res = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
            OP_LUI:  w_res = {in_imm, {(DATA_W-IMM_W){1'b0}}};
            default: w_res = '0;
        endcase
    end

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Buffer next state; vacated entries are zeroed so idle outputs read 0
    always_comb begin
        w_count_nxt = r_count;
        w_res0_nxt  = r_res0;
        w_res1_nxt  = r_res1;
        w_exc0_nxt  = r_exc0;
        w_exc1_nxt  = r_exc1;
        if (flush) begin
            w_count_nxt = CNT_0;
            w_res0_nxt  = '0;
            w_res1_nxt  = '0;
            w_exc0_nxt  = 1'b0;
            w_exc1_nxt  = 1'b0;
        end else begin
            case (r_count)
                CNT_0: begin
                    if (w_push) begin
                        w_res0_nxt  = w_res;
                        w_exc0_nxt  = w_exc;
                        w_count_nxt = CNT_1;
                    end
                end
                CNT_1: begin
                    if (w_push && w_pop) begin
                        w_res0_nxt = w_res;
                        w_exc0_nxt = w_exc;
                    end else if (w_push) begin
                        w_res1_nxt  = w_res;
                        w_exc1_nxt  = w_exc;
                        w_count_nxt = CNT_2;
                    end else if (w_pop) begin
                        w_res0_nxt  = '0;
                        w_exc0_nxt  = 1'b0;
                        w_count_nxt = CNT_0;
                    end
                end
                CNT_2: begin
                    if (w_pop) begin
                        w_res0_nxt  = r_res1;
                        w_exc0_nxt  = r_exc1;
                        w_res1_nxt  = '0;
                        w_exc1_nxt  = 1'b0;
                        w_count_nxt = CNT_1;
                    end
                end
                default: w_count_nxt = CNT_0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= CNT_0;
            r_res0      <= '0;
            r_res1      <= '0;
            r_exc0      <= 1'b0;
            r_exc1      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_res0      <= w_res0_nxt;
            r_res1      <= w_res1_nxt;
            r_exc0      <= w_exc0_nxt;
            r_exc1      <= w_exc1_nxt;
            r_in_ready  <= (w_count_nxt != CNT_2);
            r_out_valid <= (w_count_nxt != CNT_0);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_res0;
    assign out_exc    = r_exc0;

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: directed vector table, buffer corner sequences and a
// randomized run against a queue-based reference model.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [1:0]  in_addr;
    logic [31:0] in_data;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_exc;

    int n_checks = 0;
    int n_err    = 0;

    logic [32:0] mq[$];   // {exc, result} of buffered beats, head first

    ext_pipe #(.DATA_W(32), .IMM_W(16)) dut (
        .clk(clk), .reset(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_data(in_data), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [15:0] imm;
        logic [31:0] exp_res;
        logic        exp_exc;
    } vec_t;

    // Reference extension from plain arithmetic on the op rules
    function automatic logic [32:0] ref_ext(input logic [2:0] op, input logic [1:0] addr,
                                            input logic [31:0] data, input logic [15:0] imm);
        int unsigned sh;
        logic [31:0] b, h, iv;
        sh = 8 * int'(addr);
        b  = (data >> sh) & 32'hFF;
        h  = (data >> sh) & 32'hFFFF;
        iv = {16'h0, imm};
        case (op)
            3'd0: return (addr != 0) ? {1'b1, 32'h0} : {1'b0, data};
            3'd1: return {1'b0, b};
            3'd2: return {1'b0, (b >= 128) ? b + 32'hFFFF_FF00 : b};
            3'd3: return (addr % 2 == 1) ? {1'b1, 32'h0} : {1'b0, h};
            3'd4: return (addr % 2 == 1) ? {1'b1, 32'h0}
                         : {1'b0, (h >= 32768) ? h + 32'hFFFF_0000 : h};
            3'd5: return {1'b0, iv};
            3'd6: return {1'b0, (iv >= 32768) ? iv + 32'hFFFF_0000 : iv};
            default: return {1'b0, iv * 32'd65536};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, mq.size() != 2});
        if (mq.size() != 0) begin
            chk("out_result", out_result, mq[0][31:0]);
            chk("out_exc", {31'b0, out_exc}, {31'b0, mq[0][32]});
        end
    endtask

    // One clock: inputs were set at the previous negedge; model updates with the edge
    task automatic cycle();
        logic push, pop, fl;
        logic [32:0] nv;
        push = in_valid && (mq.size() < 2);
        pop  = out_ready && (mq.size() > 0);
        fl   = flush;
        nv   = ref_ext(in_op, in_addr, in_data, in_imm);
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (pop)  mq.delete(0);
            if (push) mq.push_back(nv);
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic set_in(input logic v, input logic [2:0] op, input logic [1:0] a,
                          input logic [31:0] d, input logic [15:0] im);
        in_valid = v; in_op = op; in_addr = a; in_data = d; in_imm = im;
    endtask

    vec_t vt[15];

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 3'd0, 2'd0, 32'h0, 16'h0);

        vt[0]  = '{3'd2, 2'd1, 32'h8899_AABB, 16'h0,    32'hFFFF_FFAA, 1'b0};
        vt[1]  = '{3'd1, 2'd3, 32'h8899_AABB, 16'h0,    32'h0000_0088, 1'b0};
        vt[2]  = '{3'd4, 2'd2, 32'h8899_AABB, 16'h0,    32'hFFFF_8899, 1'b0};
        vt[3]  = '{3'd3, 2'd0, 32'h8899_AABB, 16'h0,    32'h0000_AABB, 1'b0};
        vt[4]  = '{3'd6, 2'd0, 32'h0,         16'h8001, 32'hFFFF_8001, 1'b0};
        vt[5]  = '{3'd5, 2'd0, 32'h0,         16'h8001, 32'h0000_8001, 1'b0};
        vt[6]  = '{3'd7, 2'd0, 32'h0,         16'h8001, 32'h8001_0000, 1'b0};
        vt[7]  = '{3'd4, 2'd1, 32'h8899_AABB, 16'h0,    32'h0000_0000, 1'b1};
        vt[8]  = '{3'd0, 2'd2, 32'h8899_AABB, 16'h0,    32'h0000_0000, 1'b1};
        vt[9]  = '{3'd2, 2'd3, 32'h8899_AABB, 16'h0,    32'hFFFF_FF88, 1'b0};
        vt[10] = '{3'd0, 2'd0, 32'h8899_AABB, 16'h0,    32'h8899_AABB, 1'b0};
        vt[11] = '{3'd3, 2'd3, 32'h8899_AABB, 16'h0,    32'h0000_0000, 1'b1};
        vt[12] = '{3'd6, 2'd3, 32'hFFFF_FFFF, 16'h1234, 32'h0000_1234, 1'b0};
        vt[13] = '{3'd1, 2'd0, 32'h8899_AABB, 16'h0,    32'h0000_00BB, 1'b0};
        vt[14] = '{3'd3, 2'd2, 32'h7F00_1234, 16'h0,    32'h0000_7F00, 1'b0};

        // Reset state
        #12;
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst out_result", out_result, 32'd0);
        chk("rst out_exc", {31'b0, out_exc}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_check();

        // Directed vectors, streaming with out_ready=1
        out_ready = 1'b1;
        foreach (vt[i]) begin
            set_in(1'b1, vt[i].op, vt[i].addr, vt[i].data, vt[i].imm);
            cycle();
            chk($sformatf("vec%0d valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("vec%0d result", i), out_result, vt[i].exp_res);
            chk($sformatf("vec%0d exc", i), {31'b0, out_exc}, {31'b0, vt[i].exp_exc});
        end
        in_valid = 1'b0;
        cycle();
        chk("drain valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: A, B held, extra beat ignored, then ordered drain
        out_ready = 1'b0;
        set_in(1'b1, 3'd0, 2'd0, 32'hAAAA_0001, 16'h0);
        cycle();
        set_in(1'b1, 3'd0, 2'd0, 32'hBBBB_0002, 16'h0);
        cycle();
        chk("bp in_ready full", {31'b0, in_ready}, 32'd0);
        chk("bp head A", out_result, 32'hAAAA_0001);
        set_in(1'b1, 3'd0, 2'd0, 32'hDDDD_0003, 16'h0);
        cycle();
        chk("bp head held", out_result, 32'hAAAA_0001);
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        chk("bp second B", out_result, 32'hBBBB_0002);
        chk("bp in_ready after pop", {31'b0, in_ready}, 32'd1);
        cycle();
        chk("bp empty", {31'b0, out_valid}, 32'd0);

        // Flush with one entry buffered and a concurrent push of C
        out_ready = 1'b0;
        set_in(1'b1, 3'd5, 2'd0, 32'h0, 16'h0011);
        cycle();
        set_in(1'b1, 3'd5, 2'd0, 32'h0, 16'h0CCC);
        flush = 1'b1;
        cycle();
        chk("flush out_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            cycle();
            chk("flush no C", {31'b0, out_valid}, 32'd0);
        end

        // Reset mid-stream with two entries buffered
        out_ready = 1'b0;
        set_in(1'b1, 3'd0, 2'd0, 32'h1111_2222, 16'h0);
        cycle();
        set_in(1'b1, 3'd0, 2'd0, 32'h3333_4444, 16'h0);
        cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst out_result", out_result, 32'd0);
        chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        cycle();
        chk("post-rst no stale", {31'b0, out_valid}, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), $urandom, 16'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 31) == 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, registered successor to the combinational immediate extender.
- Performs immediate zero/sign/upper extension and load-data lane selection with byte/half/word extension in one unit.
- Output sits behind a 2-entry valid/ready skid buffer. Sits between the MEM-stage data-memory read port (or ID immediate field) and writeback; supports stall, flush and misalignment reporting.

Parameters:
- DATA_W, 32, datapath width; multiple of 8, >= 32.
- IMM_W, 16, immediate field width; IMM_W <= DATA_W/2.
- OFF_W, derived = log2(DATA_W/8), byte-offset width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit can accept a beat.
- in_op  in  3  operation select (see Behaviour).
- in_addr  in  OFF_W  byte offset of the load within the word.
- in_data  in  DATA_W  raw memory word.
- in_imm  in  IMM_W  immediate field.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  extended result.
- out_exc  out  1  misaligned access flag for this result.

Behaviour:
- Ops, with off = in_addr:
  - 000 WORD: pass in_data.
  - 001 LBU: zero-extend byte in_data[8*off +: 8].
  - 010 LB: sign-extend that byte.
  - 011 LHU: zero-extend half in_data[8*off +: 16].
  - 100 LH: sign-extend that half.
  - 101 IMMZ: zero-extend in_imm.
  - 110 IMMS: sign-extend in_imm.
  - 111 LUI: in_imm << (DATA_W-IMM_W), low bits 0.
- Misalignment:
  - WORD with off != 0 -> exc=1, result 0.
  - LHU/LH with off[0]=1 -> exc=1, result 0.
  - Byte and imm ops never raise exc; in_addr is ignored for imm ops.
- Computation is combinational on the input. Result and exc are written into the buffer on accept (in_valid & in_ready). Latency is 1 cycle: an accepted beat is visible at out_valid on the next edge.
- Buffer: 2 entries, FIFO order, count in {0,1,2}.
  - in_ready = (count != 2). It depends only on registered state, with no combinational path from out_ready.
  - out_valid = (count != 0). out_result/out_exc are taken from the head entry.
  - Pop when out_valid & out_ready. Push when in_valid & in_ready.
  - Simultaneous push and pop at count=1: count stays 1 and the new entry becomes head on the next cycle.
  - Push at count=2 cannot occur (in_ready=0); in_valid is ignored.
  - Pop at count=0 is ignored.
  - out_result/out_exc are held stable while out_valid=1 and out_ready=0.
- Flush: on the next edge count=0 and both entries are invalidated. Flush overrides a same-cycle push and pop; the beat presented during a flush cycle is discarded.
- Reset (reset=0, asynchronous, any time including mid-transfer): count=0, out_valid=0, out_result=0, out_exc=0, in_ready=1 after release. Entry storage is cleared to 0.
- Undefined op encodings: none, since all 8 are defined.
- Width rules: sign bit is bit 7 (byte), bit 15 (half), bit IMM_W-1 (imm). All extension fills to DATA_W.

Test Plan:
- Reset mid-stream: 2 entries buffered, assert reset low -> out_valid=0, out_result=0, in_ready=1 immediately after release; no stale data emitted.
- Extension values: in_data=32'h8899_AABB with out_ready=1:
  - LB off=1 -> 32'hFFFF_FFAA.
  - LBU off=3 -> 32'h0000_0088.
  - LH off=2 -> 32'hFFFF_8899.
  - LHU off=0 -> 32'h0000_AABB.
  - Each appears one cycle after accept.
- Immediates: in_imm=16'h8001:
  - IMMS -> 32'hFFFF_8001.
  - IMMZ -> 32'h0000_8001.
  - LUI -> 32'h8001_0000.
- Misalignment: LH off=1 -> out_exc=1, out_result=0. WORD off=2 -> out_exc=1. LB off=3 -> out_exc=0.
- Backpressure: hold out_ready=0 and push A, B -> in_ready=0 after 2nd accept and out_result stays A. Then out_ready=1 for 2 cycles -> A then B in order, in_ready=1 after first pop.
- Flush: count=1 plus push C in the same cycle with flush=1 -> next cycle out_valid=0, count=0, and C is never emitted.
